// File: rtl/seq_1010_generator.sv
// Burst generator for the serial pattern 1010, either chained (overlapping) or
// separated by a 00 gap, with a valid/ready output and a per-pattern marker.
module seq_1010_generator (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] reps,
  input  logic       overlap,
  input  logic       out_ready,
  output logic       out,
  output logic       out_valid,
  output logic       mark,
  output logic       busy,
  output logic       done,
  output logic [3:0] sent_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B0   = 3'd2,
    B1B  = 3'd3,
    B0B  = 3'd4,
    GAP0 = 3'd5,
    GAP1 = 3'd6,
    DONE = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] reps_q, reps_d;
  logic       ovl_q, ovl_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_q, out_d;
  logic       valid_q, valid_d;
  logic       mark_q, mark_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Handshake: a bit moves on a rising edge with out_valid=1 and out_ready=1.
  // out_valid never drops without a transfer, and out/mark are stable while
  // out_valid=1 and out_ready=0 because the state only moves on a transfer.
  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = 4'd0;
          if (reps != 4'd0) begin
            reps_d  = reps;
            ovl_d   = overlap;
            state_d = B1;
          end else begin
            state_d = DONE;
          end
        end
      end
      B1:   if (out_ready) state_d = B0;
      B0:   if (out_ready) state_d = B1B;
      B1B:  if (out_ready) state_d = B0B;
      B0B: begin
        if (out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == reps_q)  state_d = DONE;
          else if (ovl_q)       state_d = B1B;
          else                  state_d = GAP0;
        end
      end
      GAP0: if (out_ready) state_d = GAP1;
      GAP1: if (out_ready) state_d = B1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    out_d   = (state_d == B1) || (state_d == B1B);
    valid_d = (state_d == B1) || (state_d == B0) || (state_d == B1B) ||
              (state_d == B0B) || (state_d == GAP0) || (state_d == GAP1);
    mark_d  = (state_d == B0B);
    busy_d  = valid_d;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      reps_q  <= 4'd0;
      ovl_q   <= 1'b0;
      cnt_q   <= 4'd0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      mark_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      mark_q  <= mark_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = valid_q;
  assign mark       = mark_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_seq_1010_generator.sv
// Testbench for seq_1010_generator: directed scenarios plus randomized bursts
// checked against a stream-level model (pattern concatenation + 1010 detector).
module tb_seq_1010_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] reps;
  logic       overlap;
  logic       out_ready;
  logic       out;
  logic       out_valid;
  logic       mark;
  logic       busy;
  logic       done;
  logic [3:0] sent_count;
  logic [2:0] state_dbg;

  int n_cmp;
  int n_err;

  seq_1010_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .reps       (reps),
    .overlap    (overlap),
    .out_ready  (out_ready),
    .out        (out),
    .out_valid  (out_valid),
    .mark       (mark),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one burst starting at the current negedge.
  // stall_mode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles on bit stall_at.
  // poke: pulse start randomly during the burst and in the DONE cycle.
  task automatic run_burst(input logic [3:0] r, input bit ov, input int stall_mode,
                           input int stall_at, input bit poke, input string tag);
    logic       seq_q[$];
    logic       exp_q[$];
    logic       exp_m[$];
    logic [3:0] win;
    logic [3:0] exp_sent;
    int         popped;
    int         stall_left;
    int         budget;

    for (int p = 0; p < int'(r); p++) begin
      if (p == 0) begin
        seq_q.push_back(1'b1); seq_q.push_back(1'b0);
        seq_q.push_back(1'b1); seq_q.push_back(1'b0);
      end else if (ov) begin
        seq_q.push_back(1'b1); seq_q.push_back(1'b0);
      end else begin
        seq_q.push_back(1'b0); seq_q.push_back(1'b0);
        seq_q.push_back(1'b1); seq_q.push_back(1'b0);
        seq_q.push_back(1'b1); seq_q.push_back(1'b0);
      end
    end
    win = 4'd0;
    foreach (seq_q[i]) begin
      win = {win[2:0], seq_q[i]};
      exp_q.push_back(seq_q[i]);
      exp_m.push_back(win == 4'b1010);
    end

    start     = 1'b1;
    reps      = r;
    overlap   = ov;
    out_ready = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reps    = 4'($urandom);
    overlap = 1'($urandom);

    popped     = 0;
    stall_left = 3;
    exp_sent   = 4'd0;
    budget     = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      budget++;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s valid bit%0d: got %b expected 1", tag, popped + 1, out_valid);
      end
      n_cmp++;
      if (out !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s out bit%0d: got %b expected %b", tag, popped + 1, out, exp_q[0]);
      end
      n_cmp++;
      if (mark !== exp_m[0]) begin
        n_err++;
        $display("FAIL %s mark bit%0d: got %b expected %b", tag, popped + 1, mark, exp_m[0]);
      end
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy/done bit%0d: got %b/%b expected 1/0", tag, popped + 1, busy, done);
      end
      n_cmp++;
      if (sent_count !== exp_sent) begin
        n_err++;
        $display("FAIL %s sent_count bit%0d: got %0d expected %0d", tag, popped + 1, sent_count, exp_sent);
      end

      if (stall_mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_mode == 2 && popped + 1 == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      reps  = 4'($urandom_range(1, 15));
      if (out_ready && out_valid === 1'b1) begin
        if (exp_m[0]) exp_sent++;
        void'(exp_q.pop_front());
        void'(exp_m.pop_front());
        popped++;
      end
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d bits expected %0d", tag, popped, seq_q.size());
    end

    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 1'b0 || mark !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_cycle: got done=%b valid=%b busy=%b out=%b mark=%b expected 1,0,0,0,0",
               tag, done, out_valid, busy, out, mark);
    end
    n_cmp++;
    if (sent_count !== r) begin
      n_err++;
      $display("FAIL %s final_count: got %0d expected %0d", tag, sent_count, r);
    end

    start     = poke;
    reps      = 4'd7;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b valid=%b busy=%b expected 0,0,0", tag, done, out_valid, busy);
    end
    n_cmp++;
    if (sent_count !== r) begin
      n_err++;
      $display("FAIL %s count_hold: got %0d expected %0d", tag, sent_count, r);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: got valid=%b done=%b expected 0,0", tag, out_valid, done);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b1;
    reps      = 4'd5;
    overlap   = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out, out_valid, mark, busy, done} !== 5'b0 || sent_count !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: got out/valid/mark/busy/done=%b count=%0d expected 0",
               {out, out_valid, mark, busy, done}, sent_count);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got valid=%b busy=%b done=%b expected 0,0,0", out_valid, busy, done);
    end
  endtask

  task automatic test_gap_reps2();
    run_burst(4'd2, 1'b0, 0, 0, 1'b0, "gap_reps2");
  endtask

  task automatic test_chain_reps3();
    run_burst(4'd3, 1'b1, 0, 0, 1'b0, "chain_reps3");
  endtask

  task automatic test_stall();
    run_burst(4'd1, 1'b0, 2, 2, 1'b0, "stall");
  endtask

  task automatic test_reps_zero();
    run_burst(4'd0, 1'b0, 0, 0, 1'b0, "reps_zero");
  endtask

  task automatic test_reset_mid_burst();
    start     = 1'b1;
    reps      = 4'd4;
    overlap   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset bit3: got valid=%b out=%b expected 1,1", out_valid, out);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out, out_valid, mark, busy, done} !== 5'b0 || sent_count !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset outputs: got out/valid/mark/busy/done=%b count=%0d expected 0",
               {out, out_valid, mark, busy, done}, sent_count);
    end
    reset = 1'b0;
    run_burst(4'd1, 1'b0, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_start_ignored();
    run_burst(4'd3, 1'b0, 0, 0, 1'b1, "start_ignored");
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_burst(4'($urandom_range(0, 15)), 1'($urandom), 1, 0, 1'($urandom), "random");
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    reps      = 4'd0;
    overlap   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_gap_reps2();
    test_chain_reps3();
    test_stall();
    test_reps_zero();
    test_reset_mid_burst();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
